// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing blocks.
// Holds the 640x480@60 and 800x600@60 geometries, a total() helper
// that sums one axis, and a width helper for sizing position counters.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz, 40 MHz pixel clock (positive syncs on real monitors)
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int width_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers.
// master: the generator (takes ena, drives beam position, syncs, strobes).
// slave : a pixel pipeline or the PMOD driver (drives ena, reads the rest).
interface vga_timing_gen_if #(
  parameter int H_W     = 10,
  parameter int V_W     = 10,
  parameter int FRAME_W = 8
) ();
  logic               ena;
  logic               pix_stb;
  logic [H_W-1:0]     hpos;
  logic [V_W-1:0]     vpos;
  logic               display_on;
  logic               hsync;
  logic               vsync;
  logic               line_end;
  logic               frame_end;
  logic [FRAME_W-1:0] frame;

  modport master (
    input  ena,
    output pix_stb, hpos, vpos, display_on, hsync, vsync,
           line_end, frame_end, frame
  );

  modport slave (
    output ena,
    input  pix_stb, hpos, vpos, display_on, hsync, vsync,
           line_end, frame_end, frame
  );
endinterface

// File: rtl/vga_timing_gen_pix_strobe_div.sv
// pix_strobe_div: divides clk by CLK_DIV into a one-clk pixel strobe.
// Ports: clk, rst_n (async active-low), ena (count enable; low holds the
// phase), pix_stb (high in the cycle the divider sits on its last count).
// With CLK_DIV=1 there is no state and pix_stb follows ena directly.
module pix_strobe_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic pix_stb
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("pix_strobe_div: CLK_DIV must be >= 1");
  end else if (CLK_DIV == 1) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign pix_stb = ena;
  end else begin : g_div
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;
    logic          at_last;

    assign at_last = (div == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        div <= '0;
      end else if (ena) begin
        div <= at_last ? '0 : div + DW'(1);
      end
    end

    assign pix_stb = ena & at_last;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Ports: clk, rst_n (async active-low) and a vga_timing_gen_if.master
// bundle: ena in; pix_stb, hpos, vpos, display_on, hsync, vsync,
// line_end, frame_end, frame out.
// Position registers advance on pix_stb; everything else is a
// zero-latency decode of the registered position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FP      = VGA640_H_FP,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BP      = VGA640_H_BP,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FP      = VGA640_V_FP,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BP      = VGA640_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 1,
  parameter int H_W       = 10,
  parameter int V_W       = 10,
  parameter int FRAME_W   = 8
) (
  input logic clk,
  input logic rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CLK_DIV < 1 || FRAME_W < 1) begin : g_bad_param
    $error("vga_timing_gen: all geometry parameters and CLK_DIV must be >= 1");
  end
  if ((1 << H_W) < H_TOTAL) begin : g_bad_hw
    $error("vga_timing_gen: H_W too narrow for H_TOTAL");
  end
  if ((1 << V_W) < V_TOTAL) begin : g_bad_vw
    $error("vga_timing_gen: V_W too narrow for V_TOTAL");
  end

  // Sync windows end before the back porch, so every bound fits the counter width.
  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic               pix_stb;
  logic [H_W-1:0]     hpos;
  logic [V_W-1:0]     vpos;
  logic [FRAME_W-1:0] frame;
  logic               h_last;
  logic               v_last;
  logic               in_hsync;
  logic               in_vsync;

  pix_strobe_div #(.CLK_DIV(CLK_DIV)) u_pix_strobe_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (vga.ena),
    .pix_stb (pix_stb)
  );

  assign h_last = (hpos == H_LAST);
  assign v_last = (vpos == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos  <= '0;
      vpos  <= '0;
      frame <= '0;
    end else if (pix_stb) begin
      if (h_last) begin
        hpos <= '0;
        if (v_last) begin
          vpos  <= '0;
          frame <= frame + FRAME_W'(1);
        end else begin
          vpos <= vpos + V_W'(1);
        end
      end else begin
        hpos <= hpos + H_W'(1);
      end
    end
  end

  assign in_hsync = (hpos >= HS_START) && (hpos < HS_END);
  assign in_vsync = (vpos >= VS_START) && (vpos < VS_END);

  assign vga.pix_stb    = pix_stb;
  assign vga.hpos       = hpos;
  assign vga.vpos       = vpos;
  assign vga.frame      = frame;
  assign vga.display_on = (hpos < H_ACT) && (vpos < V_ACT);
  assign vga.hsync      = in_hsync ? HSYNC_POL : ~HSYNC_POL;
  assign vga.vsync      = in_vsync ? VSYNC_POL : ~VSYNC_POL;
  assign vga.line_end   = pix_stb & h_last;
  assign vga.frame_end  = pix_stb & h_last & v_last;

endmodule
